// File: rtl/u2zm_pkg.sv
// ---------------------------------------------------------------------------
// u2zm_pkg
//
// Shared types and constants for the serial two's complement (U2) to
// sign-magnitude (ZM) converter.
//
// Contents:
//   state_e  - converter FSM states: IDLE, SHIFT, DONE
//   ST_OK    - status 2'b00, result valid and in range (also the idle status)
//   ST_OVF   - status 2'b01, operand was -2^(m-1), which has no ZM encoding
//   ST_BUSY  - status 2'b10, conversion in progress
//   Status 2'b11 is reserved and never driven.
// ---------------------------------------------------------------------------
package u2zm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_OVF  = 2'b01;
  localparam logic [1:0] ST_BUSY = 2'b10;

endpackage

// File: rtl/u2zm_bit_cell.sv
// ---------------------------------------------------------------------------
// u2zm_bit_cell
//
// One step of the copy-until-first-one-then-invert rule that negates a
// two's complement value bit-serially, LSB first. For a positive operand
// the bit passes through unchanged; for a negative operand, bits up to
// and including the first 1 are copied and every later bit is inverted.
//
// Ports:
//   op_bit     in   current operand bit
//   sign       in   operand sign (1 = negative)
//   seen       in   a 1 has already been processed at a lower bit position
//   mag_bit    out  magnitude bit for this position
//   seen_next  out  seen flag to carry to the next bit position
// ---------------------------------------------------------------------------
module u2zm_bit_cell (
  input  logic op_bit,
  input  logic sign,
  input  logic seen,
  output logic mag_bit,
  output logic seen_next
);

  assign mag_bit   = (sign && seen) ? ~op_bit : op_bit;
  // Tracking the flag for positive operands too is harmless: it only
  // affects mag_bit when sign is set.
  assign seen_next = seen | op_bit;

endmodule

// File: rtl/u2_to_zm_serial.sv
// ---------------------------------------------------------------------------
// u2_to_zm_serial
//
// Sequential converter from two's complement (U2) to sign-magnitude (ZM).
// One m-bit operand is accepted on an input valid/ready handshake, its
// magnitude is derived one bit per cycle LSB first (m-1 SHIFT cycles),
// and the ZM result plus a 2-bit status are presented on an output
// valid/ready handshake. One conversion takes m+1 cycles end to end when
// the consumer is always ready.
//
// Parameters:
//   m         operand/result width, m >= 2; bit m-1 is the sign
//
// Ports:
//   i_clk     in   clock, rising edge
//   i_rst     in   asynchronous active-high reset
//   i_valid   in   operand present on i_argA
//   o_ready   out  block can accept an operand (IDLE only)
//   i_argA    in   signed U2 operand, sampled only on the acceptance edge
//   o_valid   out  o_result/o_status hold a completed conversion (DONE)
//   i_ready   in   consumer takes the result; ignored outside DONE
//   o_result  out  ZM result: bit m-1 sign, bits m-2..0 magnitude
//   o_status  out  ST_OK / ST_OVF / ST_BUSY
//
// Build option:
//   U2ZM_SAT_EN  when defined, an overflow operand (-2^(m-1)) yields
//                all ones (largest negative magnitude); otherwise it
//                yields 1 followed by zeros. Status is ST_OVF either way
//                and timing is identical in both builds.
// ---------------------------------------------------------------------------
module u2_to_zm_serial
  import u2zm_pkg::*;
#(
  parameter int m = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [m-1:0] i_argA,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [m-1:0] o_result,
  output logic [1:0]   o_status
);

  localparam int CW = $clog2(m);

  state_e         state_q;
  state_e         state_d;

  logic [m-2:0]   op_q;       // unprocessed operand bits, LSB at op_q[0]
  logic [m-2:0]   mag_q;      // magnitude bits collected so far, shifted in from the top
  logic           sign_q;
  logic           seen_q;
  logic           ovf_q;
  logic [CW-1:0]  cnt_q;
  logic [m-1:0]   res_q;

  logic           mag_bit;
  logic           seen_nxt;
  logic           last_bit;
  logic           ovf_in;
  logic [m-1:0]   mag_shift;
  logic [m-1:0]   res_final;

  // -------------------------------------------------------------------------
  // Bit cell: one instance, fed from the bottom of the operand shift register
  // -------------------------------------------------------------------------
  u2zm_bit_cell u_cell (
    .op_bit    (op_q[0]),
    .sign      (sign_q),
    .seen      (seen_q),
    .mag_bit   (mag_bit),
    .seen_next (seen_nxt)
  );

  // New magnitude bit enters at the top; after m-1 shifts the first
  // processed bit has reached position 0.
  assign mag_shift = {mag_bit, mag_q};
  assign last_bit  = (state_q == SHIFT) && (cnt_q == CW'(m - 2));

  // -2^(m-1) is the only U2 value whose magnitude does not fit in m-1 bits.
  assign ovf_in    = i_argA[m-1] && (i_argA[m-2:0] == '0);

  always_comb begin
    if (ovf_q) begin
`ifdef U2ZM_SAT_EN
      res_final = '1;
`else
      res_final = {1'b1, {(m-1){1'b0}}};
`endif
    end else begin
      res_final = {sign_q, mag_shift[m-1:1]};
    end
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and handshake/status outputs
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    state_d  = state_q;
    o_ready  = 1'b0;
    o_valid  = 1'b0;
    o_status = ST_OK;

    case (state_q)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        o_status = ST_BUSY;
        if (last_bit) begin
          state_d = DONE;
        end
      end

      DONE: begin
        o_valid  = 1'b1;
        o_status = ovf_q ? ST_OVF : ST_OK;
        if (i_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: operand capture, serial conversion, result register
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      op_q   <= '0;
      mag_q  <= '0;
      sign_q <= 1'b0;
      seen_q <= 1'b0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
      res_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            op_q   <= i_argA[m-2:0];
            sign_q <= i_argA[m-1];
            ovf_q  <= ovf_in;
            mag_q  <= '0;
            seen_q <= 1'b0;
            cnt_q  <= '0;
          end
        end

        SHIFT: begin
          op_q   <= op_q >> 1;
          mag_q  <= mag_shift[m-1:1];
          seen_q <= seen_nxt;
          cnt_q  <= cnt_q + CW'(1);
          if (last_bit) begin
            res_q <= res_final;
          end
        end

        default: begin
          // DONE: everything holds so the result is stable under backpressure.
        end
      endcase
    end
  end

  assign o_result = res_q;

endmodule

// File: tb/tb_u2_to_zm_serial.sv
// ---------------------------------------------------------------------------
// tb_u2_to_zm_serial
//
// Directed self-checking bench for u2_to_zm_serial with m = 4. Expected
// results are hand-computed ZM encodings. Honours U2ZM_SAT_EN for the
// overflow result.
// ---------------------------------------------------------------------------
module tb_u2_to_zm_serial;

  localparam int M = 4;

  localparam logic [1:0] S_OK   = 2'b00;
  localparam logic [1:0] S_OVF  = 2'b01;
  localparam logic [1:0] S_BUSY = 2'b10;

`ifdef U2ZM_SAT_EN
  localparam logic [M-1:0] OVF_RES = 4'b1111;
`else
  localparam logic [M-1:0] OVF_RES = 4'b1000;
`endif

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_valid;
  logic         i_ready;
  logic [M-1:0] i_argA;
  logic         o_ready;
  logic         o_valid;
  logic [M-1:0] o_result;
  logic [1:0]   o_status;

  int tests_run    = 0;
  int tests_failed = 0;

  u2_to_zm_serial #(.m(M)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_argA   (i_argA),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_status (o_status)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // One full conversion, entered and left at #1 after a rising edge.
  // hold_ready keeps i_ready high during the whole job; stall holds the
  // result in DONE with i_ready low for that many cycles first.
  task automatic run_one(input string tag, input logic [M-1:0] a,
                         input logic [M-1:0] exp_res, input logic [1:0] exp_st,
                         input logic hold_ready, input int stall);
    int lat;
    check({tag, ".ready_idle"}, o_ready, 1);
    i_argA  = a;
    i_valid = 1'b1;
    i_ready = hold_ready;
    step();
    i_valid = 1'b0;
    i_argA  = ~a;  // must not disturb the captured operand
    check({tag, ".busy"}, o_status, S_BUSY);
    check({tag, ".not_ready"}, o_ready, 0);
    lat = 0;
    while (!o_valid && lat < 20) begin
      step();
      lat++;
    end
    check({tag, ".latency"}, lat, 3);
    check({tag, ".result"}, o_result, exp_res);
    check({tag, ".status"}, o_status, exp_st);
    for (int i = 0; i < stall; i++) begin
      i_valid = 1'b1;  // must not be accepted while in DONE
      i_argA  = 4'b0110;
      step();
      check({tag, ".stall_valid"}, o_valid, 1);
      check({tag, ".stall_ready"}, o_ready, 0);
      check({tag, ".stall_result"}, o_result, exp_res);
      check({tag, ".stall_status"}, o_status, exp_st);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    check({tag, ".released"}, o_valid, 0);
    check({tag, ".back_idle"}, o_ready, 1);
  endtask

  logic [M-1:0] vin  [3];
  logic [M-1:0] vexp [3];
  int           tv   [3];
  int           nin;
  int           nout;
  logic         prev_ready;

  initial begin
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_argA  = '0;
    #12;
    check("reset.ready",  o_ready,  1);
    check("reset.valid",  o_valid,  0);
    check("reset.result", o_result, 0);
    check("reset.status", o_status, S_OK);
    @(negedge i_clk);
    i_rst = 1'b0;
    step();

    run_one("pos5", 4'b0101, 4'b0101, S_OK,  1'b1, 0);
    run_one("neg3", 4'b1101, 4'b1011, S_OK,  1'b0, 0);
    run_one("neg1", 4'b1111, 4'b1001, S_OK,  1'b0, 0);
    run_one("ovf",  4'b1000, OVF_RES, S_OVF, 1'b0, 0);
    run_one("zero", 4'b0000, 4'b0000, S_OK,  1'b0, 5);

    // Reset during the second SHIFT cycle of 1010.
    i_argA  = 4'b1010;
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    step();
    check("midrst.in_shift", o_status, S_BUSY);
    i_rst = 1'b1;
    #1;
    check("midrst.ready",  o_ready,  1);
    check("midrst.valid",  o_valid,  0);
    check("midrst.result", o_result, 0);
    check("midrst.status", o_status, S_OK);
    @(negedge i_clk);
    i_rst = 1'b0;
    step();
    run_one("post_rst", 4'b0011, 4'b0011, S_OK, 1'b0, 0);

    // Back-to-back stream with i_valid and i_ready held high.
    vin[0]  = 4'b0111; vin[1]  = 4'b1001; vin[2]  = 4'b0001;
    vexp[0] = 4'b0111; vexp[1] = 4'b1111; vexp[2] = 4'b0001;
    tv[0] = 0; tv[1] = 0; tv[2] = 0;
    nin  = 0;
    nout = 0;
    i_valid = 1'b1;
    i_ready = 1'b1;
    i_argA  = vin[0];
    for (int cyc = 0; cyc < 40 && nout < 3; cyc++) begin
      prev_ready = o_ready;
      step();
      if (prev_ready && i_valid) begin
        nin++;
        if (nin < 3) i_argA = vin[nin];
        else         i_valid = 1'b0;
      end
      if (o_valid) begin
        check($sformatf("b2b.result%0d", nout), o_result, vexp[nout]);
        tv[nout] = cyc;
        nout++;
      end
    end
    i_valid = 1'b0;
    i_ready = 1'b0;
    check("b2b.count", nout, 3);
    check("b2b.gap01", tv[1] - tv[0], 5);
    check("b2b.gap12", tv[2] - tv[1], 5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
